// File: rtl/nios2_jtag_dbg_pkg.sv
// rtl/nios2_jtag_dbg_pkg.sv - shared types and default widths for the JTAG debug command bridge
package nios2_jtag_dbg_pkg;

    localparam int DEF_IR_W        = 2;
    localparam int DEF_DR_W        = 38;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FIFO_DEPTH  = 4;

    typedef enum logic {
        KIND_IR = 1'b0,
        KIND_DR = 1'b1
    } cmd_kind_e;

    typedef struct packed {
        cmd_kind_e             kind;
        logic [DEF_IR_W-1:0]   ir;
        logic [DEF_DR_W-1:0]   jdo;
    } dbg_cmd_t;

endpackage

// File: rtl/nios2_jtag_dbg_cmd_fifo.sv
// rtl/nios2_jtag_dbg_cmd_fifo.sv - first-word-fall-through command FIFO with full-with-pop bypass
module nios2_jtag_dbg_cmd_fifo #(
    parameter int W     = 41,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       head_valid,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       push_drop
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] level_q;
    logic             full;
    logic             empty;
    logic             do_pop;
    logic             do_push;

    assign full      = (level_q == LVL_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign do_pop    = pop & ~empty;
    // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
    assign do_push   = push & (~full | do_pop);
    assign push_drop = push & ~do_push;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign head       = empty ? '0 : mem[rd_ptr];
    assign head_valid = ~empty;
    assign level      = level_q;

endmodule

// File: rtl/nios2_jtag_debug_cmd_bridge.sv
// rtl/nios2_jtag_debug_cmd_bridge.sv - clk-side capture and buffering of virtual-JTAG IR/DR updates
module nios2_jtag_debug_cmd_bridge
    import nios2_jtag_dbg_pkg::*;
#(
    parameter int IR_W        = DEF_IR_W,
    parameter int DR_W        = DEF_DR_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [IR_W-1:0]               ir_in,
    input  logic [DR_W-1:0]               sr,
    input  logic                          vs_uir,
    input  logic                          vs_udr,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic                          cmd_kind,
    output logic [IR_W-1:0]               cmd_ir,
    output logic [DR_W-1:0]               cmd_jdo,
    output logic [2**IR_W-1:0]            action_strobe,
    output logic [2**IR_W-1:0]            no_action_strobe,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    input  logic                          overrun_clr
);
    localparam int CMD_W = 1 + IR_W + DR_W;

    logic [SYNC_STAGES-1:0] fill_q;
    logic                   chain_full;
    logic [1:0]             vs_level;
    logic [1:0]             rise;
    logic [CMD_W-1:0]       push_data;
    logic [CMD_W-1:0]       head;
    logic                   push;
    logic                   pop;
    logic                   drop_full;
    logic                   drop;

    // Marks when the last sync stage holds a real sample rather than its reset zero,
    // so a level that is already high at reset release never arms its channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_q <= '0;
        end else begin
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end
    assign chain_full = fill_q[SYNC_STAGES-1];

    assign vs_level = {vs_udr, vs_uir};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   hist_q;
        logic                   armed_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q  <= '0;
                hist_q  <= 1'b0;
                armed_q <= 1'b0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], vs_level[ch]};
                hist_q  <= sync_q[SYNC_STAGES-1];
                armed_q <= armed_q | (chain_full & ~sync_q[SYNC_STAGES-1]);
            end
        end

        assign rise[ch] = sync_q[SYNC_STAGES-1] & ~hist_q & armed_q;
    end

    // rise[1] is the DR channel; it wins when both channels fire together.
    always_comb begin
        push_data = {1'(KIND_IR), ir_in, {DR_W{1'b0}}};
        if (rise[1]) begin
            push_data = {1'(KIND_DR), ir_in, sr};
        end
    end
    assign push = |rise;
    assign pop  = cmd_valid & cmd_ready;

    nios2_jtag_dbg_cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head       (head),
        .head_valid (cmd_valid),
        .level      (fifo_level),
        .push_drop  (drop_full)
    );

    assign {cmd_kind, cmd_ir, cmd_jdo} = head;

    always_comb begin
        action_strobe    = '0;
        no_action_strobe = '0;
        if (pop) begin
            if (cmd_kind == 1'(KIND_DR)) begin
                action_strobe[cmd_ir] = 1'b1;
            end else begin
                no_action_strobe[cmd_ir] = 1'b1;
            end
        end
    end

    assign drop = (&rise) | drop_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule
